load_scheduler: RTL
===================

# load_scheduler

Sequencer placed in front of the tile's load unit. It accepts one two-operand load request at a time from the aggregation datapath and issues it to the load unit for one cycle. It collects each operand from either the local memory (fixed 1-cycle read latency) or the remote fetch unit (variable latency), then presents both operands together on a valid/ready output. It also keeps saturating counters of local and remote operand traffic.

## Interface
- X_COORD, 1, tile x coordinate; passed to the load unit instance and used for nothing else.
- Y_COORD, 1, tile y coordinate; same use as X_COORD.
- DATA_WIDTH, 32, operand width.
- CNT_WIDTH, 16, width of each performance counter.

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  request valid.
- in_rdy  out  1  request accepted when in_vld && in_rdy.
- in_addr1, in_addr2  in  ADDR_LENGTH each  operand addresses.
- ld_req_vld  out  1  request strobe to the load unit.
- ld_addr1, ld_addr2  out  ADDR_LENGTH each  registered addresses to the load unit.
- ld_mem_vld1, ld_mem_vld2  in  1 each  load-unit decode: operand is local.
- ld_fetch_vld1, ld_fetch_vld2  in  1 each  load-unit decode: operand is remote.
- mem_rdata1, mem_rdata2  in  DATA_WIDTH each  local RAM data, valid one cycle after the matching ld_mem_vld.
- fetch_rsp_vld1, fetch_rsp_vld2  in  1 each  remote response strobe per operand slot.
- fetch_rsp_data1, fetch_rsp_data2  in  DATA_WIDTH each  remote response data.
- out_vld  out  1  operand pair valid.
- out_rdy  in  1  consumer ready.
- out_data1, out_data2  out  DATA_WIDTH each  registered operands.
- busy  out  1  high in every state except IDLE.
- cnt_local, cnt_remote  out  CNT_WIDTH each  operands served locally or remotely.

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE
  - in_rdy=1.
  - On acceptance: register in_addr1/2 into ld_addr1/2, then go to ISSUE.
- ISSUE (exactly one cycle)
  - ld_req_vld=1.
  - Latch the decode into per-slot flags: loc1/loc2 from ld_mem_vld, pend1/pend2 from ld_fetch_vld.
  - Clear got1/got2.
  - Go to WAIT.
- WAIT
  - First WAIT cycle: each slot with loc set captures its mem_rdata and sets got.
  - Any WAIT cycle: each slot with pend set and fetch_rsp_vld high captures fetch_rsp_data, sets got and clears pend.
  - Go to OUT in the cycle after got1 && got2 becomes true.
- OUT
  - out_vld=1; out_data held stable.
  - On out_rdy go to IDLE, so in_rdy is seen high the following cycle.
- Fetch responses outside WAIT, or on a slot whose pend is clear, are ignored and do not disturb data or flags.
- Both slots may respond in the same cycle; both are captured.
- Both operands may be local, both remote, or mixed.
- Counters
  - cnt_local += (loc1 + loc2) in the ISSUE cycle.
  - cnt_remote += (pend1 + pend2) in the ISSUE cycle.
  - Each counter saturates at all-ones with no wrap.
  - Counters are cleared only by rst.
- No timeout: WAIT persists until all pending responses arrive.

## Timing
- Reset values: state IDLE, in_rdy=1, ld_req_vld=0, ld_addr1/2=0, out_vld=0, out_data1/2=0, busy=0, cnt_local=cnt_remote=0, all flags 0.
- Reset mid-operation: next cycle is IDLE with all flags and outputs at their reset values; stale fetch responses arriving afterwards are ignored.
- All-local request accepted at cycle T:
  - ld_req_vld at T+1.
  - Capture at T+2.
  - out_vld at T+3.
- Remote slot:
  - Earliest response is T+2.
  - out_vld is asserted the cycle after the last required capture.
- Back-to-back throughput: one request per 4 cycles when all operands are local and out_rdy=1.
- out_vld, once raised, stays high until out_rdy, with data unchanged.

## Test plan
- Reset then idle: rst for 2 cycles -> all outputs at reset values; in_rdy=1; busy=0.
- Both local:
  - Stimulus: in_addr1 = x=1,y=1,row 5 and in_addr2 = row 9 at T; mem_rdata1=0xAAAA, mem_rdata2=0xBBBB at T+2.
  - Response: ld_req_vld only at T+1; out_vld at T+3 with 0xAAAA/0xBBBB; cnt_local=2.
- Mixed:
  - Stimulus: slot1 local, slot2 remote (x=2,y=0); fetch_rsp_vld2 with 0x1234 at T+7.
  - Response: out_vld at T+8; out_data2=0x1234; cnt_local=1, cnt_remote=1.
- Both remote, responses in the same cycle T+5 -> both captured; out_vld at T+6.
- Spurious and backpressure:
  - fetch_rsp_vld1 during IDLE -> ignored.
  - out_rdy held low for 5 cycles in OUT -> out_vld and data stable; in_rdy=0 throughout.
- Reset in WAIT with a remote fetch pending; response arrives 2 cycles after reset -> FSM stays IDLE; out_vld=0; counters 0.

Source files
------------

// File: rtl/load_scheduler.sv
// -----------------------------------------------------------------------------
// load_scheduler
//
// Sequencer in front of the tile load unit. Accepts one two-operand load
// request at a time, strobes it to the load unit for a single cycle, gathers
// each operand from local memory (fixed one-cycle read latency) or from the
// remote fetch unit (variable latency), then presents both operands together
// on a valid/ready output. Saturating counters track how many operands were
// served locally and remotely.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   in_vld / in_rdy                 request handshake
//   in_addr1, in_addr2              operand addresses of the request
//   ld_req_vld                      one-cycle request strobe to the load unit
//   ld_addr1, ld_addr2              registered addresses to the load unit
//   ld_mem_vld1/2, ld_fetch_vld1/2  load-unit decode (local / remote) per slot
//   mem_rdata1/2                    local RAM data, one cycle after decode
//   fetch_rsp_vld1/2, _data1/2      remote responses per operand slot
//   out_vld / out_rdy               operand pair handshake
//   out_data1, out_data2            registered operands
//   busy                            high whenever the sequencer is not idle
//   cnt_local, cnt_remote           saturating operand traffic counters
// -----------------------------------------------------------------------------
module load_scheduler #(
  parameter int X_COORD     = 1,
  parameter int Y_COORD     = 1,
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int ADDR_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [ADDR_LENGTH-1:0] in_addr1,
  input  logic [ADDR_LENGTH-1:0] in_addr2,
  output logic                   ld_req_vld,
  output logic [ADDR_LENGTH-1:0] ld_addr1,
  output logic [ADDR_LENGTH-1:0] ld_addr2,
  input  logic                   ld_mem_vld1,
  input  logic                   ld_mem_vld2,
  input  logic                   ld_fetch_vld1,
  input  logic                   ld_fetch_vld2,
  input  logic [DATA_WIDTH-1:0]  mem_rdata1,
  input  logic [DATA_WIDTH-1:0]  mem_rdata2,
  input  logic                   fetch_rsp_vld1,
  input  logic                   fetch_rsp_vld2,
  input  logic [DATA_WIDTH-1:0]  fetch_rsp_data1,
  input  logic [DATA_WIDTH-1:0]  fetch_rsp_data2,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [DATA_WIDTH-1:0]  out_data1,
  output logic [DATA_WIDTH-1:0]  out_data2,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   cnt_local,
  output logic [CNT_WIDTH-1:0]   cnt_remote
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // The tile coordinates only matter to the load unit's address decode, which
  // lives outside this block; the scheduler never looks at them. The empty
  // block below documents the legal coordinate range.
  if ((X_COORD < 0) || (Y_COORD < 0)) begin : g_bad_coord
  end

  // Add a 0..2 increment to a counter, sticking at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] value,
    input logic [1:0]           inc
  );
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, value} + {{(CNT_WIDTH-1){1'b0}}, inc};
    if (sum[CNT_WIDTH]) begin
      sat_add = {CNT_WIDTH{1'b1}};
    end else begin
      sat_add = sum[CNT_WIDTH-1:0];
    end
  endfunction

  state_t                  state_r;
  state_t                  state_next_s;

  logic                    in_rdy_r;
  logic                    ld_req_vld_r;
  logic                    out_vld_r;
  logic                    busy_r;
  logic                    in_rdy_next_s;
  logic                    ld_req_vld_next_s;
  logic                    out_vld_next_s;
  logic                    busy_next_s;

  logic [ADDR_LENGTH-1:0]  ld_addr1_r;
  logic [ADDR_LENGTH-1:0]  ld_addr2_r;
  logic [DATA_WIDTH-1:0]   data1_r;
  logic [DATA_WIDTH-1:0]   data2_r;
  logic [CNT_WIDTH-1:0]    cnt_local_r;
  logic [CNT_WIDTH-1:0]    cnt_remote_r;

  // Per-slot bookkeeping: loc = served from local RAM, pend = still waiting on
  // a remote response, got = operand captured. first_wait_r marks the single
  // cycle in which local RAM data is valid.
  logic                    loc1_r;
  logic                    loc2_r;
  logic                    pend1_r;
  logic                    pend2_r;
  logic                    got1_r;
  logic                    got2_r;
  logic                    first_wait_r;

  logic                    accept_s;
  logic                    cap_loc1_s;
  logic                    cap_loc2_s;
  logic                    cap_rem1_s;
  logic                    cap_rem2_s;
  logic                    got1_next_s;
  logic                    got2_next_s;
  logic [1:0]              local_inc_s;
  logic [1:0]              remote_inc_s;

  // Capture strobes and the resulting got flags for this cycle.
  always_comb begin
    accept_s     = in_vld && in_rdy_r;
    cap_loc1_s   = (state_r == ST_WAIT) && first_wait_r && loc1_r;
    cap_loc2_s   = (state_r == ST_WAIT) && first_wait_r && loc2_r;
    // Remote responses only count on a slot still pending, and only in WAIT.
    cap_rem1_s   = (state_r == ST_WAIT) && pend1_r && fetch_rsp_vld1;
    cap_rem2_s   = (state_r == ST_WAIT) && pend2_r && fetch_rsp_vld2;
    got1_next_s  = got1_r || cap_loc1_s || cap_rem1_s;
    got2_next_s  = got2_r || cap_loc2_s || cap_rem2_s;
    local_inc_s  = {1'b0, ld_mem_vld1} + {1'b0, ld_mem_vld2};
    remote_inc_s = {1'b0, ld_fetch_vld1} + {1'b0, ld_fetch_vld2};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. WAIT leaves on the same edge that completes the pair, so
  // OUT is entered the cycle after the last capture.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (got1_next_s && got2_next_s) begin
          state_next_s = ST_OUT;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (out_rdy) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_OUT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the handshake outputs can be
  // registered and still line up with the state they describe.
  always_comb begin
    in_rdy_next_s     = 1'b0;
    ld_req_vld_next_s = 1'b0;
    out_vld_next_s    = 1'b0;
    busy_next_s       = 1'b1;
    case (state_next_s)
      ST_IDLE: begin
        in_rdy_next_s = 1'b1;
        busy_next_s   = 1'b0;
      end
      ST_ISSUE: begin
        ld_req_vld_next_s = 1'b1;
      end
      ST_WAIT: begin
        busy_next_s = 1'b1;
      end
      ST_OUT: begin
        out_vld_next_s = 1'b1;
      end
      default: begin
        in_rdy_next_s = 1'b1;
        busy_next_s   = 1'b0;
      end
    endcase
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_rdy_r     <= 1'b1;
      ld_req_vld_r <= 1'b0;
      out_vld_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      in_rdy_r     <= in_rdy_next_s;
      ld_req_vld_r <= ld_req_vld_next_s;
      out_vld_r    <= out_vld_next_s;
      busy_r       <= busy_next_s;
    end
  end

  // Request address capture on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_addr1_r <= {ADDR_LENGTH{1'b0}};
      ld_addr2_r <= {ADDR_LENGTH{1'b0}};
    end else if (accept_s) begin
      ld_addr1_r <= in_addr1;
      ld_addr2_r <= in_addr2;
    end
  end

  // Slot flags: latch the load-unit decode in ISSUE, then track captures.
  always_ff @(posedge clk) begin
    if (rst) begin
      loc1_r       <= 1'b0;
      loc2_r       <= 1'b0;
      pend1_r      <= 1'b0;
      pend2_r      <= 1'b0;
      got1_r       <= 1'b0;
      got2_r       <= 1'b0;
      first_wait_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ISSUE: begin
          loc1_r       <= ld_mem_vld1;
          loc2_r       <= ld_mem_vld2;
          pend1_r      <= ld_fetch_vld1;
          pend2_r      <= ld_fetch_vld2;
          got1_r       <= 1'b0;
          got2_r       <= 1'b0;
          first_wait_r <= 1'b1;
        end
        ST_WAIT: begin
          first_wait_r <= 1'b0;
          got1_r       <= got1_next_s;
          got2_r       <= got2_next_s;
          if (cap_rem1_s) begin
            pend1_r <= 1'b0;
          end
          if (cap_rem2_s) begin
            pend2_r <= 1'b0;
          end
        end
        default: begin
          first_wait_r <= 1'b0;
        end
      endcase
    end
  end

  // Operand capture; data only moves in WAIT, so it is frozen throughout OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      data1_r <= {DATA_WIDTH{1'b0}};
      data2_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (cap_loc1_s) begin
        data1_r <= mem_rdata1;
      end else if (cap_rem1_s) begin
        data1_r <= fetch_rsp_data1;
      end
      if (cap_loc2_s) begin
        data2_r <= mem_rdata2;
      end else if (cap_rem2_s) begin
        data2_r <= fetch_rsp_data2;
      end
    end
  end

  // Traffic counters, bumped once per request from the decode seen in ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_local_r  <= {CNT_WIDTH{1'b0}};
      cnt_remote_r <= {CNT_WIDTH{1'b0}};
    end else if (state_r == ST_ISSUE) begin
      cnt_local_r  <= sat_add(cnt_local_r, local_inc_s);
      cnt_remote_r <= sat_add(cnt_remote_r, remote_inc_s);
    end
  end

  assign in_rdy     = in_rdy_r;
  assign ld_req_vld = ld_req_vld_r;
  assign ld_addr1   = ld_addr1_r;
  assign ld_addr2   = ld_addr2_r;
  assign out_vld    = out_vld_r;
  assign out_data1  = data1_r;
  assign out_data2  = data2_r;
  assign busy       = busy_r;
  assign cnt_local  = cnt_local_r;
  assign cnt_remote = cnt_remote_r;

endmodule
